core_pipe_reg_hs: RTL and testbench
===================================

Name: core_pipe_reg_hs

Overview:
- Parametrised pipeline-boundary register between two core stages (IF/ID is the first user; ID/EX and EX/MEM will follow).
- Carries pc, instr and snpc with a valid/ready handshake, so upstream and downstream can stall independently.
- Provides a synchronous flush that kills in-flight beats and injects a NOP bubble.
- Has an optional skid slot, giving full throughput with a registered in_ready, plus a bubble-cycle performance counter.

Parameters:
PC_W, 64, width of pc and snpc fields
INSTR_W, 32, width of instr field
NOP_INSTR, 32'h00000013, instr value driven whenever out_valid=0 (RV addi x0,x0,0)
SKID, 1, 1 = two-entry stage (main + skid) with registered in_ready; 0 = single entry with combinational in_ready
CNT_W, 32, width of bubble counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat
pc_i  in  PC_W  upstream pc
instr_i  in  INSTR_W  upstream instruction
snpc_i  in  PC_W  upstream static next pc
out_valid  out  1  downstream beat valid
out_ready  in  1  downstream accepts beat
pc_o  out  PC_W  registered pc
instr_o  out  INSTR_W  registered instruction
snpc_o  out  PC_W  registered snpc
flush  in  1  synchronous kill of all held and incoming beats
bubble_cnt_o  out  CNT_W  count of cycles with out_valid=0 since reset

Behaviour:
- Handshake:
  - Accept = in_valid & in_ready.
  - Retire = out_valid & out_ready.
  - Payload outputs come straight from the main register; no combinational path from inputs to out_* in either SKID mode.
- Reset (rst=1):
  - main_valid=0, skid_valid=0, so out_valid=0.
  - pc_o=0, snpc_o=0, instr_o=NOP_INSTR, bubble_cnt_o=0.
  - in_ready=1 in the cycle after reset.
- Reset has priority over flush; flush has priority over all data movement.
- Invariant: whenever out_valid=0, instr_o=NOP_INSTR and pc_o=snpc_o=0. Any transition of main to empty loads these values.
- Latency: an accepted beat appears on out_* one cycle after acceptance when main is empty or retiring; otherwise it waits behind the held beat(s). Order is strictly FIFO.
- SKID=1:
  - in_ready = ~skid_valid, registered.
  - On accept, if main is empty or retiring, and skid is empty: beat -> main.
  - On accept, if main is full and not retiring: beat -> skid.
  - On retire with skid_valid=1: skid -> main, skid empties. A simultaneous accept then goes to skid.
  - On retire with skid empty and no accept: main empties and loads bubble values.
  - Sustained in_valid=out_ready=1 gives 1 beat/cycle.
  - With out_ready=0 the stage absorbs exactly 2 beats, then in_ready=0.
- SKID=0:
  - in_ready = ~main_valid | out_ready, combinational.
  - Skid logic is absent, and skid_valid is tied 0.
- Flush (flush=1, rst=0):
  - Next cycle: main_valid=0, skid_valid=0, and bubble payload is loaded.
  - A beat accepted in the flush cycle is discarded. in_ready is not gated by flush.
  - A retire in the flush cycle still counts as delivered downstream.
- Bubble counter:
  - Increments by 1 on each rising edge where rst=0 and the current out_valid=0.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Unaffected by flush.
- Payload registers are never written on cycles without accept, retire, flush or reset; held beats stay bit-stable under backpressure.

Test Plan:
- Reset, then idle 5 cycles with in_valid=0 -> out_valid=0, instr_o=32'h00000013, pc_o=0, in_ready=1, bubble_cnt_o=5.
- SKID=1, out_ready=1, stream pc=0x1000,0x1004,0x1008 (instr 0xA,0xB,0xC) on consecutive cycles -> same values on out_* one cycle later each, back-to-back, in_ready stays 1.
- SKID=1, out_ready=0, push pc=0x2000 then 0x2004 -> in_ready=0 after the second accept, pc_o=0x2000 held stable. Raise out_ready for 2 cycles -> 0x2000 then 0x2004 retired, in_ready=1 again, no loss or duplication.
- SKID=1, both entries full, assert flush for 1 cycle with in_valid=1, pc_i=0x3000 -> next cycle out_valid=0, instr_o=NOP_INSTR, pc_o=0; 0x3000 never appears.
- SKID=0, main full, out_ready toggles 0->1 -> in_ready follows out_ready in the same cycle, and a beat is accepted and retired simultaneously with no bubble.
- CNT_W=4, idle 20 cycles after reset -> bubble_cnt_o reaches 15 and stays 15. Assert rst -> 0.

Source files
------------

// File: rtl/core_pipe_reg_hs.sv
// Pipeline-boundary register between two core stages.
// Carries pc/instr/snpc with a valid/ready handshake, a synchronous flush
// that injects a NOP bubble, an optional skid entry for full throughput with
// a registered in_ready, and a saturating bubble-cycle counter.
module core_pipe_reg_hs #(
  parameter int unsigned                PC_W      = 64,
  parameter int unsigned                INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]         NOP_INSTR = INSTR_W'(32'h00000013),
  parameter bit                         SKID      = 1'b1,
  parameter int unsigned                CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    snpc_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    snpc_o,
  input  logic               flush,
  output logic [CNT_W-1:0]   bubble_cnt_o
);

  logic               accept;
  logic               retire;

  logic               main_valid_q, main_valid_d;
  logic               main_we;
  logic [PC_W-1:0]    main_pc_q, main_pc_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [PC_W-1:0]    main_snpc_q, main_snpc_d;

  // Skid view seen by the main-entry logic; constant empty when SKID=0.
  logic               skid_valid;
  logic [PC_W-1:0]    skid_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_snpc;

  logic [CNT_W-1:0]   bubble_cnt_q, bubble_cnt_d;

  assign accept = in_valid & in_ready;
  assign retire = main_valid_q & out_ready;

  // Main entry next-state: flush wins, then refill from skid, then from input,
  // otherwise an emptying main reloads bubble values.
  always_comb begin
    main_we      = 1'b0;
    main_valid_d = main_valid_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
    main_snpc_d  = main_snpc_q;
    if (flush) begin
      main_we      = 1'b1;
      main_valid_d = 1'b0;
      main_pc_d    = '0;
      main_instr_d = NOP_INSTR;
      main_snpc_d  = '0;
    end else if (!main_valid_q || retire) begin
      if (skid_valid) begin
        main_we      = 1'b1;
        main_valid_d = 1'b1;
        main_pc_d    = skid_pc;
        main_instr_d = skid_instr;
        main_snpc_d  = skid_snpc;
      end else if (accept) begin
        main_we      = 1'b1;
        main_valid_d = 1'b1;
        main_pc_d    = pc_i;
        main_instr_d = instr_i;
        main_snpc_d  = snpc_i;
      end else if (main_valid_q) begin
        main_we      = 1'b1;
        main_valid_d = 1'b0;
        main_pc_d    = '0;
        main_instr_d = NOP_INSTR;
        main_snpc_d  = '0;
      end
    end
  end

  // Main entry registers; payload only written when something moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_pc_q    <= '0;
      main_instr_q <= NOP_INSTR;
      main_snpc_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      if (main_we) begin
        main_pc_q    <= main_pc_d;
        main_instr_q <= main_instr_d;
        main_snpc_q  <= main_snpc_d;
      end
    end
  end

  generate
    if (SKID) begin : g_skid
      logic               skid_valid_q, skid_valid_d;
      logic               skid_we;
      logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
      logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
      logic [PC_W-1:0]    skid_snpc_q, skid_snpc_d;

      // Skid entry next-state: capture a beat that main cannot take this
      // cycle, drain into main on retire.
      always_comb begin
        skid_we      = 1'b0;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        skid_snpc_d  = skid_snpc_q;
        if (flush) begin
          skid_valid_d = 1'b0;
        end else if (accept && main_valid_q && !retire) begin
          skid_we      = 1'b1;
          skid_valid_d = 1'b1;
          skid_pc_d    = pc_i;
          skid_instr_d = instr_i;
          skid_snpc_d  = snpc_i;
        end else if (skid_valid_q && retire) begin
          if (accept) begin
            skid_we      = 1'b1;
            skid_valid_d = 1'b1;
            skid_pc_d    = pc_i;
            skid_instr_d = instr_i;
            skid_snpc_d  = snpc_i;
          end else begin
            skid_valid_d = 1'b0;
          end
        end
      end

      // Skid entry registers.
      always_ff @(posedge clk) begin
        if (rst) begin
          skid_valid_q <= 1'b0;
          skid_pc_q    <= '0;
          skid_instr_q <= NOP_INSTR;
          skid_snpc_q  <= '0;
        end else begin
          skid_valid_q <= skid_valid_d;
          if (skid_we) begin
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_snpc_q  <= skid_snpc_d;
          end
        end
      end

      assign skid_valid = skid_valid_q;
      assign skid_pc    = skid_pc_q;
      assign skid_instr = skid_instr_q;
      assign skid_snpc  = skid_snpc_q;
      // Driven purely from a flop, so no input-to-in_ready path.
      assign in_ready   = ~skid_valid_q;
    end else begin : g_noskid
      assign skid_valid = 1'b0;
      assign skid_pc    = '0;
      assign skid_instr = NOP_INSTR;
      assign skid_snpc  = '0;
      assign in_ready   = ~main_valid_q | out_ready;
    end
  endgenerate

  // Bubble counter next-state: saturating increment on empty-output cycles.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!main_valid_q && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  // Bubble counter register; flush does not touch it.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign out_valid    = main_valid_q;
  assign pc_o         = main_pc_q;
  assign instr_o      = main_instr_q;
  assign snpc_o       = main_snpc_q;
  assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_core_pipe_reg_hs.sv
// Scoreboard bench for core_pipe_reg_hs: SKID=1 instance, SKID=0 instance
// and a CNT_W=4 instance for counter saturation.
module tb_core_pipe_reg_hs;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] snpc;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst_c;
  logic mon_en = 1'b0;

  // Instance A: SKID=1
  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, flush_a;
  logic [63:0] pc_a, snpc_a, pc_o_a, snpc_o_a;
  logic [31:0] instr_a, instr_o_a, bub_a;
  // Instance B: SKID=0
  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, flush_b;
  logic [63:0] pc_b, snpc_b, pc_o_b, snpc_o_b;
  logic [31:0] instr_b, instr_o_b, bub_b;
  // Instance C: CNT_W=4, always idle
  logic        in_valid_c, in_ready_c, out_valid_c, out_ready_c, flush_c;
  logic [63:0] pc_c, snpc_c, pc_o_c, snpc_o_c;
  logic [31:0] instr_c, instr_o_c;
  logic [3:0]  bub_c;

  beat_t q_a[$];
  beat_t q_b[$];
  int checks = 0;
  int errors = 0;

  core_pipe_reg_hs #(.SKID(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .pc_i(pc_a), .instr_i(instr_a), .snpc_i(snpc_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .pc_o(pc_o_a), .instr_o(instr_o_a), .snpc_o(snpc_o_a),
    .flush(flush_a), .bubble_cnt_o(bub_a)
  );

  core_pipe_reg_hs #(.SKID(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .pc_i(pc_b), .instr_i(instr_b), .snpc_i(snpc_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .pc_o(pc_o_b), .instr_o(instr_o_b), .snpc_o(snpc_o_b),
    .flush(flush_b), .bubble_cnt_o(bub_b)
  );

  core_pipe_reg_hs #(.SKID(1'b1), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .pc_i(pc_c), .instr_i(instr_c), .snpc_i(snpc_c),
    .out_valid(out_valid_c), .out_ready(out_ready_c),
    .pc_o(pc_o_c), .instr_o(instr_o_c), .snpc_o(snpc_o_c),
    .flush(flush_c), .bubble_cnt_o(bub_c)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor A: pop on every retire, check bubble invariant otherwise.
  always @(negedge clk) begin : mon_a
    beat_t e;
    if (mon_en && !rst) begin
      if (out_valid_a && out_ready_a) begin
        if (q_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_a unexpected beat: got pc %h expected no beat", pc_o_a);
        end else begin
          e = q_a.pop_front();
          check("mon_a pc", pc_o_a, e.pc);
          check("mon_a instr", {32'b0, instr_o_a}, {32'b0, e.instr});
          check("mon_a snpc", snpc_o_a, e.snpc);
        end
      end else if (!out_valid_a) begin
        check("mon_a bubble instr", {32'b0, instr_o_a}, {32'b0, NOP});
        check("mon_a bubble pc", pc_o_a, 64'd0);
        check("mon_a bubble snpc", snpc_o_a, 64'd0);
      end
    end
  end

  // Monitor B: same scoreboard for the SKID=0 instance.
  always @(negedge clk) begin : mon_b
    beat_t e;
    if (mon_en && !rst) begin
      if (out_valid_b && out_ready_b) begin
        if (q_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_b unexpected beat: got pc %h expected no beat", pc_o_b);
        end else begin
          e = q_b.pop_front();
          check("mon_b pc", pc_o_b, e.pc);
          check("mon_b instr", {32'b0, instr_o_b}, {32'b0, e.instr});
          check("mon_b snpc", snpc_o_b, e.snpc);
        end
      end else if (!out_valid_b) begin
        check("mon_b bubble instr", {32'b0, instr_o_b}, {32'b0, NOP});
        check("mon_b bubble pc", pc_o_b, 64'd0);
      end
    end
  end

  // Offer one beat to A, wait (bounded) for acceptance, push expectation.
  task automatic send_a(input logic [63:0] pc, input logic [31:0] instr, input bit push);
    int n = 0;
    in_valid_a = 1'b1;
    pc_a       = pc;
    instr_a    = instr;
    snpc_a     = pc + 64'd4;
    @(negedge clk);
    while (!in_ready_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_a) begin
      checks++;
      errors++;
      $display("FAIL send_a timeout pc %h: in_ready 0 expected 1", pc);
    end else if (push) begin
      q_a.push_back(beat_t'{pc: pc, instr: instr, snpc: pc + 64'd4});
    end
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rst_c = 1'b1;
    in_valid_a = 0; out_ready_a = 0; flush_a = 0; pc_a = '0; instr_a = '0; snpc_a = '0;
    in_valid_b = 0; out_ready_b = 0; flush_b = 0; pc_b = '0; instr_b = '0; snpc_b = '0;
    in_valid_c = 0; out_ready_c = 1; flush_c = 0; pc_c = '0; instr_c = '0; snpc_c = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; rst_c = 1'b0; mon_en = 1'b1;

    // Reset state and idle bubble counting
    repeat (5) @(posedge clk);
    #1;
    check("reset out_valid", out_valid_a, 0);
    check("reset instr_o", {32'b0, instr_o_a}, {32'b0, NOP});
    check("reset pc_o", pc_o_a, 0);
    check("reset snpc_o", snpc_o_a, 0);
    check("reset in_ready", in_ready_a, 1);
    check("idle bubble_cnt a", bub_a, 5);
    check("idle bubble_cnt b", bub_b, 5);
    check("idle bubble_cnt c", bub_c, 5);
    check("reset in_ready b", in_ready_b, 1);

    // SKID=1 streaming, one cycle latency, full throughput
    out_ready_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_a(64'h1000 + 64'(4 * i), 32'hA + 32'(i), 1'b1);
      check("stream in_ready", in_ready_a, 1);
      check("stream out_valid", out_valid_a, 1);
      check("stream pc_o", pc_o_a, 64'h1000 + 64'(4 * i));
    end
    @(posedge clk);
    #1;
    check("stream drained out_valid", out_valid_a, 0);
    check("stream queue empty", 64'(q_a.size()), 0);

    // SKID=1 backpressure: absorb two beats, hold, then drain in order
    out_ready_a = 1'b0;
    send_a(64'h2000, 32'h20, 1'b1);
    check("bp first in_ready", in_ready_a, 1);
    send_a(64'h2004, 32'h21, 1'b1);
    check("bp full in_ready", in_ready_a, 0);
    check("bp full pc_o", pc_o_a, 64'h2000);
    repeat (3) @(posedge clk);
    #1;
    check("bp hold pc_o", pc_o_a, 64'h2000);
    check("bp hold instr_o", {32'b0, instr_o_a}, 64'h20);
    check("bp hold in_ready", in_ready_a, 0);
    out_ready_a = 1'b1;
    @(posedge clk);
    #1;
    check("bp drain1 pc_o", pc_o_a, 64'h2004);
    check("bp drain1 in_ready", in_ready_a, 1);
    @(posedge clk);
    #1;
    out_ready_a = 1'b0;
    check("bp drain2 out_valid", out_valid_a, 0);
    check("bp queue empty", 64'(q_a.size()), 0);

    // Flush with both entries full; incoming beat must vanish
    send_a(64'h2100, 32'h30, 1'b1);
    send_a(64'h2104, 32'h31, 1'b1);
    check("flush pre in_ready", in_ready_a, 0);
    flush_a = 1'b1; in_valid_a = 1'b1; pc_a = 64'h3000; instr_a = 32'h33; snpc_a = 64'h3004;
    @(posedge clk);
    #1;
    flush_a = 1'b0; in_valid_a = 1'b0;
    q_a.delete();
    check("flush out_valid", out_valid_a, 0);
    check("flush instr_o", {32'b0, instr_o_a}, {32'b0, NOP});
    check("flush pc_o", pc_o_a, 0);
    check("flush snpc_o", snpc_o_a, 0);
    check("flush in_ready", in_ready_a, 1);

    // Flush on an empty stage: the beat accepted in the flush cycle is dropped
    flush_a = 1'b1; in_valid_a = 1'b1; pc_a = 64'h3004; instr_a = 32'h34; snpc_a = 64'h3008;
    @(posedge clk);
    #1;
    flush_a = 1'b0; in_valid_a = 1'b0;
    check("flush accept dropped", out_valid_a, 0);
    out_ready_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("flush no late beat", out_valid_a, 0);

    // Retire coinciding with flush is still delivered
    send_a(64'h2200, 32'h40, 1'b1);
    flush_a = 1'b1;
    @(posedge clk);
    #1;
    flush_a = 1'b0;
    check("flush retire out_valid", out_valid_a, 0);
    check("flush retire delivered", 64'(q_a.size()), 0);
    out_ready_a = 1'b0;

    // SKID=0: combinational in_ready, simultaneous accept and retire
    in_valid_b = 1'b1; pc_b = 64'h4000; instr_b = 32'h50; snpc_b = 64'h4004;
    @(negedge clk);
    check("b first in_ready", in_ready_b, 1);
    q_b.push_back(beat_t'{pc: 64'h4000, instr: 32'h50, snpc: 64'h4004});
    @(posedge clk);
    #1;
    in_valid_b = 1'b0;
    check("b full out_valid", out_valid_b, 1);
    check("b full pc_o", pc_o_b, 64'h4000);
    check("b full in_ready", in_ready_b, 0);
    in_valid_b = 1'b1; pc_b = 64'h4004; instr_b = 32'h51; snpc_b = 64'h4008;
    #1;
    check("b blocked in_ready", in_ready_b, 0);
    out_ready_b = 1'b1;
    #1;
    check("b follows out_ready", in_ready_b, 1);
    q_b.push_back(beat_t'{pc: 64'h4004, instr: 32'h51, snpc: 64'h4008});
    @(posedge clk);
    #1;
    in_valid_b = 1'b0;
    check("b no bubble out_valid", out_valid_b, 1);
    check("b no bubble pc_o", pc_o_b, 64'h4004);
    @(posedge clk);
    #1;
    out_ready_b = 1'b0;
    check("b drained out_valid", out_valid_b, 0);
    check("b queue empty", 64'(q_b.size()), 0);

    // CNT_W=4 saturation and reset clear
    repeat (20) @(posedge clk);
    #1;
    check("cnt saturated", bub_c, 15);
    repeat (3) @(posedge clk);
    #1;
    check("cnt no wrap", bub_c, 15);
    rst_c = 1'b1;
    @(posedge clk);
    #1;
    check("cnt reset", bub_c, 0);
    rst_c = 1'b0;
    @(posedge clk);
    #1;
    check("cnt restart", bub_c, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
